// File: rtl/alu_issue_stage.sv
// ID/EX issue register feeding the ALU: operand forwarding, Y select, ALUControl decode.
// Define ALU_ISSUE_FORWARDING_EN to enable the EX/MEM and MEM/WB bypass network.
module alu_issue_stage #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [XLEN-1:0]       RD1,
    input  logic [XLEN-1:0]       RD2,
    input  logic [XLEN-1:0]       Imm,
    input  logic [REG_ADDR_W-1:0] Rs1,
    input  logic [REG_ADDR_W-1:0] Rs2,
    input  logic [REG_ADDR_W-1:0] Rd,
    input  logic                  ALUSrc,
    input  logic [1:0]            ALUOp,
    input  logic [2:0]            Funct3,
    input  logic                  Funct7b5,
    input  logic                  RegWrite,
    input  logic                  Flush,
    input  logic                  ExMemRegWrite,
    input  logic [REG_ADDR_W-1:0] ExMemRd,
    input  logic [XLEN-1:0]       ExMemResult,
    input  logic                  MemWbRegWrite,
    input  logic [REG_ADDR_W-1:0] MemWbRd,
    input  logic [XLEN-1:0]       MemWbResult,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [XLEN-1:0]       X,
    output logic [XLEN-1:0]       Y,
    output logic [3:0]            ALUControl,
    output logic [XLEN-1:0]       StoreData,
    output logic [REG_ADDR_W-1:0] OutRd,
    output logic                  OutRegWrite,
    output logic                  IllegalOp
);

    logic                  r_valid;
    logic [XLEN-1:0]       r_x;
    logic [XLEN-1:0]       r_y;
    logic [3:0]            r_ctrl;
    logic [XLEN-1:0]       r_store;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_regwrite;
    logic                  r_illegal;

    logic                  w_in_ready;
    logic [XLEN-1:0]       w_fwd1;
    logic [XLEN-1:0]       w_fwd2;
    logic [3:0]            w_ctrl;
    logic                  w_illegal;

    assign w_in_ready = !r_valid || OutReady;

`ifdef ALU_ISSUE_FORWARDING_EN
    // EX/MEM is younger than MEM/WB, so it wins when both target the same register.
    always_comb begin
        w_fwd1 = RD1;
        if (ExMemRegWrite && (ExMemRd == Rs1) && (Rs1 != '0))
            w_fwd1 = ExMemResult;
        else if (MemWbRegWrite && (MemWbRd == Rs1) && (Rs1 != '0))
            w_fwd1 = MemWbResult;
    end

    always_comb begin
        w_fwd2 = RD2;
        if (ExMemRegWrite && (ExMemRd == Rs2) && (Rs2 != '0))
            w_fwd2 = ExMemResult;
        else if (MemWbRegWrite && (MemWbRd == Rs2) && (Rs2 != '0))
            w_fwd2 = MemWbResult;
    end
`else
    logic w_unused;

    assign w_fwd1   = RD1;
    assign w_fwd2   = RD2;
    assign w_unused = ^{Rs1, Rs2, ExMemRegWrite, ExMemRd, ExMemResult,
                        MemWbRegWrite, MemWbRd, MemWbResult};
`endif

    always_comb begin
        w_ctrl    = 4'b0010;
        w_illegal = 1'b0;
        case (ALUOp)
            2'b00: w_ctrl = 4'b0010;
            2'b01: w_ctrl = 4'b0110;
            2'b10: begin
                case (Funct3)
                    3'b000:  w_ctrl = (Funct7b5 && !ALUSrc) ? 4'b0110 : 4'b0010;
                    3'b111:  w_ctrl = 4'b0000;
                    3'b110:  w_ctrl = 4'b0001;
                    default: w_illegal = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Flush outranks capture; a drain clears only the control bits, data regs hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_ctrl     <= 4'b0000;
            r_store    <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (Flush) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
        end else if (InValid && w_in_ready) begin
            r_valid    <= 1'b1;
            r_x        <= w_fwd1;
            r_y        <= ALUSrc ? Imm : w_fwd2;
            r_ctrl     <= w_ctrl;
            r_store    <= w_fwd2;
            r_rd       <= Rd;
            r_regwrite <= RegWrite;
            r_illegal  <= w_illegal;
        end else if (OutReady) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
        end
    end

    assign InReady     = w_in_ready;
    assign OutValid    = r_valid;
    assign X           = r_x;
    assign Y           = r_y;
    assign ALUControl  = r_ctrl;
    assign StoreData   = r_store;
    assign OutRd       = r_rd;
    assign OutRegWrite = r_regwrite;
    assign IllegalOp   = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed vectors queue expected results,
// a negedge monitor pops and compares on every accepted output.
module tb_alu_issue_stage;

    localparam int XLEN = 64;
    localparam int RAW  = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            InValid;
    logic            InReady;
    logic [XLEN-1:0] RD1, RD2, Imm;
    logic [RAW-1:0]  Rs1, Rs2, Rd;
    logic            ALUSrc;
    logic [1:0]      ALUOp;
    logic [2:0]      Funct3;
    logic            Funct7b5;
    logic            RegWrite;
    logic            Flush;
    logic            ExMemRegWrite;
    logic [RAW-1:0]  ExMemRd;
    logic [XLEN-1:0] ExMemResult;
    logic            MemWbRegWrite;
    logic [RAW-1:0]  MemWbRd;
    logic [XLEN-1:0] MemWbResult;
    logic            OutValid;
    logic            OutReady;
    logic [XLEN-1:0] X, Y, StoreData;
    logic [3:0]      ALUControl;
    logic [RAW-1:0]  OutRd;
    logic            OutRegWrite;
    logic            IllegalOp;

    typedef struct {
        logic [XLEN-1:0] x;
        logic [XLEN-1:0] y;
        logic [3:0]      c;
        logic [XLEN-1:0] sd;
        logic            ill;
        logic [RAW-1:0]  rd;
        logic            rw;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    alu_issue_stage #(.XLEN(XLEN), .REG_ADDR_W(RAW)) dut (
        .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady),
        .RD1(RD1), .RD2(RD2), .Imm(Imm), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp), .Funct3(Funct3), .Funct7b5(Funct7b5),
        .RegWrite(RegWrite), .Flush(Flush),
        .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd), .ExMemResult(ExMemResult),
        .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd), .MemWbResult(MemWbResult),
        .OutValid(OutValid), .OutReady(OutReady), .X(X), .Y(Y),
        .ALUControl(ALUControl), .StoreData(StoreData), .OutRd(OutRd),
        .OutRegWrite(OutRegWrite), .IllegalOp(IllegalOp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && OutValid && OutReady) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got X=%0h want none", X);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("X", X, e.x);
                chk("Y", Y, e.y);
                chk("ALUControl", {60'd0, ALUControl}, {60'd0, e.c});
                chk("StoreData", StoreData, e.sd);
                chk("IllegalOp", {63'd0, IllegalOp}, {63'd0, e.ill});
                chk("OutRd", {59'd0, OutRd}, {59'd0, e.rd});
                chk("OutRegWrite", {63'd0, OutRegWrite}, {63'd0, e.rw});
            end
        end
    end

    task automatic setop(input logic [RAW-1:0] rs1, input logic [RAW-1:0] rs2,
                         input logic [RAW-1:0] rd, input logic [XLEN-1:0] rd1,
                         input logic [XLEN-1:0] rd2, input logic [XLEN-1:0] imm,
                         input logic src, input logic [1:0] op,
                         input logic [2:0] f3, input logic f7, input logic rw);
        Rs1 = rs1; Rs2 = rs2; Rd = rd; RD1 = rd1; RD2 = rd2; Imm = imm;
        ALUSrc = src; ALUOp = op; Funct3 = f3; Funct7b5 = f7; RegWrite = rw;
    endtask

    task automatic byp(input logic emw, input logic [RAW-1:0] emrd,
                       input logic [XLEN-1:0] emres, input logic mww,
                       input logic [RAW-1:0] mwrd, input logic [XLEN-1:0] mwres);
        ExMemRegWrite = emw; ExMemRd = emrd; ExMemResult = emres;
        MemWbRegWrite = mww; MemWbRd = mwrd; MemWbResult = mwres;
    endtask

    // Drive the current operands as valid for one edge; queue the expectation if it will reach the ALU.
    task automatic send(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                        input logic [3:0] c, input logic [XLEN-1:0] sd,
                        input logic ill, input bit expect_out);
        exp_t e;
        e.x = x; e.y = y; e.c = c; e.sd = sd; e.ill = ill; e.rd = Rd; e.rw = RegWrite;
        InValid = 1'b1;
        if (expect_out) exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    logic [XLEN-1:0] fx3, fx5y, fx5s, fx6s;

    initial begin
`ifdef ALU_ISSUE_FORWARDING_EN
        fx3 = 64'd23; fx5y = 64'd99; fx5s = 64'd99; fx6s = 64'd99;
`else
        fx3 = 64'd1;  fx5y = 64'd9;  fx5s = 64'd9;  fx6s = 64'd9;
`endif
        rst = 1'b1; InValid = 1'b0; Flush = 1'b0; OutReady = 1'b1;
        setop(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0);
        byp(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_OutValid", {63'd0, OutValid}, 64'd0);
        chk("rst_X", X, 64'd0);
        chk("rst_Y", Y, 64'd0);
        chk("rst_ALUControl", {60'd0, ALUControl}, 64'd0);
        chk("rst_StoreData", StoreData, 64'd0);
        chk("rst_InReady", {63'd0, InReady}, 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        setop(1, 2, 3, 64'd15, 64'd18, 64'd0, 0, 2'b10, 3'b000, 1, 1);
        send(64'd15, 64'd18, 4'b0110, 64'd18, 0, 1);
        setop(1, 2, 3, 64'd15, 64'd18, 64'd4, 1, 2'b10, 3'b000, 1, 1);
        send(64'd15, 64'd4, 4'b0010, 64'd18, 0, 1);
        byp(1, 5, 64'd23, 1, 5, 64'd99);
        setop(5, 6, 4, 64'd1, 64'd2, 64'd0, 0, 2'b00, 3'b010, 0, 1);
        send(fx3, 64'd2, 4'b0010, 64'd2, 0, 1);
        byp(1, 0, 64'd23, 1, 0, 64'd99);
        setop(0, 0, 4, 64'd41, 64'd42, 64'd0, 0, 2'b10, 3'b000, 0, 1);
        send(64'd41, 64'd42, 4'b0010, 64'd42, 0, 1);
        byp(1, 5, 64'd23, 1, 7, 64'd99);
        setop(8, 7, 9, 64'd3, 64'd9, 64'd0, 0, 2'b10, 3'b111, 0, 1);
        send(64'd3, fx5y, 4'b0000, fx5s, 0, 1);
        setop(8, 7, 9, 64'd3, 64'd9, 64'hFFFF_FFFF_FFFF_FFFB, 1, 2'b00, 3'b011, 0, 0);
        send(64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 4'b0010, fx6s, 0, 1);
        byp(0, 0, 0, 0, 0, 0);
        setop(10, 11, 12, 64'd5, 64'd6, 64'd0, 0, 2'b11, 3'b000, 0, 1);
        send(64'd5, 64'd6, 4'b0010, 64'd6, 1, 1);
        setop(10, 11, 12, 64'd5, 64'd6, 64'd0, 0, 2'b10, 3'b001, 0, 1);
        send(64'd5, 64'd6, 4'b0010, 64'd6, 1, 1);
        setop(10, 11, 13, 64'd12, 64'd10, 64'd0, 0, 2'b10, 3'b110, 0, 1);
        send(64'd12, 64'd10, 4'b0001, 64'd10, 0, 1);
        setop(10, 11, 14, 64'd77, 64'd33, 64'd0, 0, 2'b01, 3'b000, 0, 1);
        send(64'd77, 64'd33, 4'b0110, 64'd33, 0, 1);

        InValid = 1'b0;
        @(posedge clk); #1;
        chk("drain_OutValid", {63'd0, OutValid}, 64'd0);
        chk("drain_OutRegWrite", {63'd0, OutRegWrite}, 64'd0);
        chk("drain_X_kept", X, 64'd77);

        setop(1, 2, 15, 64'd7, 64'd4, 64'd0, 0, 2'b10, 3'b111, 0, 1);
        send(64'd7, 64'd4, 4'b0000, 64'd4, 0, 1);
        OutReady = 1'b0;
        setop(3, 4, 16, 64'd100, 64'd200, 64'd0, 0, 2'b10, 3'b000, 0, 1);
        exp_q.push_back('{x: 64'd100, y: 64'd200, c: 4'b0010, sd: 64'd200,
                          ill: 1'b0, rd: 5'd16, rw: 1'b1});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_InReady", {63'd0, InReady}, 64'd0);
            chk("stall_OutValid", {63'd0, OutValid}, 64'd1);
            chk("stall_X", X, 64'd7);
            chk("stall_Y", Y, 64'd4);
            chk("stall_ALUControl", {60'd0, ALUControl}, 64'd0);
        end
        OutReady = 1'b1;
        @(posedge clk); #1;
        chk("b2b_OutValid", {63'd0, OutValid}, 64'd1);
        chk("b2b_X", X, 64'd100);
        InValid = 1'b0;
        @(posedge clk); #1;

        OutReady = 1'b0;
        setop(1, 2, 17, 64'd50, 64'd60, 64'd0, 0, 2'b00, 3'b000, 0, 1);
        send(64'd50, 64'd60, 4'b0010, 64'd60, 0, 0);
        chk("pre_flush_OutValid", {63'd0, OutValid}, 64'd1);
        chk("pre_flush_OutRegWrite", {63'd0, OutRegWrite}, 64'd1);
        Flush = 1'b1;
        setop(1, 2, 18, 64'd51, 64'd61, 64'd0, 0, 2'b00, 3'b000, 0, 1);
        send(64'd51, 64'd61, 4'b0010, 64'd61, 0, 0);
        chk("flush_OutValid", {63'd0, OutValid}, 64'd0);
        chk("flush_OutRegWrite", {63'd0, OutRegWrite}, 64'd0);
        Flush = 1'b0;
        InValid = 1'b0;
        OutReady = 1'b1;

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
